// File: rtl/axi_lite_master.sv
// AXI-Lite master: turns single client requests (read or write, 128-bit data)
// into AXI-Lite channel transactions, one outstanding transaction at a time,
// and returns one response per request with a saturating latency count.
// All outputs come from registers or from the state alone, so no client or
// slave input reaches an output combinationally.
module axi_lite_master (
  input  logic         clk,
  input  logic         rst,              // asynchronous, active low

  // client request
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [31:0]  req_addr,
  input  logic [127:0] req_wdata,
  input  logic [15:0]  req_wstrb,

  // client response
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_write,
  output logic [127:0] resp_rdata,
  output logic         resp_err,
  output logic [15:0]  resp_latency,

  // read address channel
  output logic [31:0]  readAddr_addr,
  output logic         readAddr_valid,
  input  logic         readAddr_ready,

  // read data channel
  input  logic [127:0] readData_data,
  input  logic         readData_valid,
  output logic         readData_ready,

  // write address channel
  output logic [31:0]  writeAddr_addr,
  output logic         writeAddr_valid,
  input  logic         writeAddr_ready,

  // write data channel
  output logic [127:0] writeData_data,
  output logic [15:0]  writeData_strb,
  output logic         writeData_valid,
  input  logic         writeData_ready,

  // write response channel
  input  logic [31:0]  writeResp_msg,
  input  logic         writeResp_valid,
  output logic         writeResp_ready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WSEND = 3'd3,
    WRESP = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t state_q, state_d;

  // captured request
  logic         write_q, write_d;
  logic [31:0]  addr_q, addr_d;
  logic [127:0] wdata_q, wdata_d;
  logic [15:0]  wstrb_q, wstrb_d;

  // per-channel completion flags for the write address / write data channels
  logic         aw_done_q, aw_done_d;
  logic         w_done_q, w_done_d;

  // response payload
  logic [127:0] rdata_q, rdata_d;
  logic         err_q, err_d;
  logic [15:0]  lat_q, lat_d;

  // channel handshakes seen this cycle
  logic aw_hs;
  logic w_hs;
  logic both_done;

  // latency arithmetic
  logic [16:0] lat_sum;
  logic [1:0]  lat_step;

  assign aw_hs     = writeAddr_valid && writeAddr_ready;
  assign w_hs      = writeData_valid && writeData_ready;
  // Leave WSEND as soon as both channels are complete, counting a handshake
  // happening right now; this keeps the fastest write as short as a read.
  assign both_done = (aw_done_q || aw_hs) && (w_done_q || w_hs);

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = req_write ? WSEND : RADDR;
        end
      end
      RADDR: begin
        if (readAddr_ready) begin
          state_d = RDATA;
        end
      end
      RDATA: begin
        if (readData_valid) begin
          state_d = RESP;
        end
      end
      WSEND: begin
        if (both_done) begin
          state_d = WRESP;
        end
      end
      WRESP: begin
        if (writeResp_valid) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state, done flags and captured registers only.
  always_comb begin
    req_ready       = (state_q == IDLE);
    readAddr_valid  = (state_q == RADDR);
    readData_ready  = (state_q == RDATA);
    writeAddr_valid = (state_q == WSEND) && !aw_done_q;
    writeData_valid = (state_q == WSEND) && !w_done_q;
    writeResp_ready = (state_q == WRESP);
    resp_valid      = (state_q == RESP);

    readAddr_addr   = addr_q;
    writeAddr_addr  = addr_q;
    writeData_data  = wdata_q;
    writeData_strb  = wstrb_q;

    resp_write      = write_q;
    resp_rdata      = rdata_q;
    resp_err        = err_q;
    resp_latency    = lat_q;
  end

  // Latency increment: one per busy cycle, and the cycle that enters RESP is
  // counted too, so that transition adds two.
  always_comb begin
    lat_step = (state_d == RESP) ? 2'd2 : 2'd1;
    lat_sum  = {1'b0, lat_q} + {15'd0, lat_step};
  end

  // Datapath next values: capture on accept, track channel completion,
  // latch the response payload and run the saturating latency counter.
  always_comb begin
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    lat_d     = lat_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d   = req_write;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rdata_d   = '0;     // writes report zero read data
          err_d     = 1'b0;   // reads never report an error
          lat_d     = '0;
        end
      end
      RADDR, WRESP, RDATA, WSEND: begin
        lat_d = lat_sum[16] ? 16'hFFFF : lat_sum[15:0];
        if (state_q == RDATA && readData_valid) begin
          rdata_d = readData_data;
        end
        if (state_q == WRESP && writeResp_valid) begin
          err_d = (writeResp_msg != 32'd0);
        end
        if (state_q == WSEND) begin
          if (both_done) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            aw_done_d = aw_done_q || aw_hs;
            w_done_d  = w_done_q || w_hs;
          end
        end
      end
      default: begin
        // RESP holds every payload register stable
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      lat_q     <= '0;
    end else begin
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      lat_q     <= lat_d;
    end
  end

endmodule
